// File: rtl/inverse_revaluate_dp.sv
// Inverse revaluate (chi-style) datapath.
// Undoes b[i] = a[i] ^ (~a[i+1] & a[i+2]) along each 5-cell row, one cell per
// clock, using the closed-form 5-cell inverse on a snapshot taken at start.
`timescale 1ns/1ps

module inverse_revaluate_dp #(
   parameter int NUM_ROW    = 5,
   parameter int NUM_COLUMN = 5,
   parameter int NUM_PAGE   = 64,
   localparam int NUM_CELLS = NUM_ROW * NUM_COLUMN * NUM_PAGE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [NUM_CELLS-1:0] data_in,
   output logic                 busy,
   output logic                 done,
   output logic [NUM_CELLS-1:0] data_out
);

   localparam int I_W    = $clog2(NUM_ROW);
   localparam int J_W    = $clog2(NUM_COLUMN);
   localparam int K_W    = $clog2(NUM_PAGE);
   localparam int ADDR_W = $clog2(NUM_CELLS);
   localparam int ROT_W  = $clog2(2 * NUM_ROW);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [NUM_CELLS-1:0]   snapshot;
   logic [I_W-1:0]         i_cnt;
   logic [J_W-1:0]         j_cnt;
   logic [K_W-1:0]         k_cnt;
   logic                   last_cell;
   logic [ADDR_W-1:0]      row_base;
   logic [ADDR_W-1:0]      cell_addr;
   logic [NUM_ROW-1:0]     row_cells;
   logic [2*NUM_ROW-1:0]   row_twice;
   logic [ROT_W-1:0]       rot_shift;
   logic [NUM_ROW-1:0]     rot;
   logic                   cell_value;

   // The final cell of the whole state is the one with every counter at its maximum.
   assign last_cell = (i_cnt == I_W'(NUM_ROW - 1)) &&
                      (j_cnt == J_W'(NUM_COLUMN - 1)) &&
                      (k_cnt == K_W'(NUM_PAGE - 1));

   // State register; reset abandons any job in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and status outputs; start is only honoured while idle.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last_cell) begin
               state_next = DONE;
            end
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Pick the current row out of the snapshot, rotate it so the current cell sits
   // at bit 0, and apply the closed-form inverse to that rotated view.
   always_comb begin
      row_base   = ADDR_W'(k_cnt) * ADDR_W'(NUM_ROW * NUM_COLUMN) +
                   ADDR_W'(j_cnt) * ADDR_W'(NUM_ROW);
      cell_addr  = row_base + ADDR_W'(i_cnt);
      row_cells  = snapshot[row_base +: NUM_ROW];
      row_twice  = {row_cells, row_cells};
      rot_shift  = ROT_W'(i_cnt);
      rot        = row_twice[rot_shift +: NUM_ROW];
      cell_value = rot[0] ^ (~rot[1] & (rot[2] ^ (~rot[3] & rot[4])));
   end

   // Snapshot capture, counter walk and per-cell write-back of the recovered state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snapshot <= '0;
         data_out <= '0;
         i_cnt    <= '0;
         j_cnt    <= '0;
         k_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  snapshot <= data_in;
                  i_cnt    <= '0;
                  j_cnt    <= '0;
                  k_cnt    <= '0;
               end
            end
            RUN: begin
               data_out[cell_addr] <= cell_value;
               if (i_cnt == I_W'(NUM_ROW - 1)) begin
                  i_cnt <= '0;
                  if (j_cnt == J_W'(NUM_COLUMN - 1)) begin
                     j_cnt <= '0;
                     if (k_cnt == K_W'(NUM_PAGE - 1)) begin
                        k_cnt <= '0;
                     end else begin
                        k_cnt <= k_cnt + K_W'(1);
                     end
                  end else begin
                     j_cnt <= j_cnt + J_W'(1);
                  end
               end else begin
                  i_cnt <= i_cnt + I_W'(1);
               end
            end
            default: begin
               i_cnt <= '0;
               j_cnt <= '0;
               k_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inverse_revaluate_dp.sv
// Scoreboard bench for inverse_revaluate_dp: stimulus pushes the expected state
// and acceptance cycle; a monitor pops and compares on every done pulse.
`timescale 1ns/1ps

module tb_inverse_revaluate_dp;

   localparam int NUM_ROW    = 5;
   localparam int NUM_COLUMN = 5;
   localparam int NUM_PAGE   = 64;
   localparam int NUM_CELLS  = NUM_ROW * NUM_COLUMN * NUM_PAGE;
   localparam int NUM_RANDOM = 20;

   typedef logic [NUM_CELLS-1:0] vec_t;

   typedef struct {
      string name;
      vec_t  expected;
      int    acceptCycle;
   } exp_t;

   logic clock;
   logic reset;
   logic start;
   vec_t dataIn;
   logic busy;
   logic done;
   vec_t dataOut;

   exp_t expQ[$];
   int   cycleCount;
   int   checksDone;
   int   checksPassed;

   inverse_revaluate_dp #(
      .NUM_ROW(NUM_ROW),
      .NUM_COLUMN(NUM_COLUMN),
      .NUM_PAGE(NUM_PAGE)
   ) dut (
      .clk(clock),
      .rst(reset),
      .start(start),
      .data_in(dataIn),
      .busy(busy),
      .done(done),
      .data_out(dataOut)
   );

   // Free-running 100 MHz clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Cycle counter used to measure start-to-done latency.
   initial cycleCount = 0;
   always @(posedge clock) cycleCount <= cycleCount + 1;

   // Scalar comparison with a FAIL line on mismatch.
   task automatic checkOutput(input string name, input longint actual, input longint required);
      checksDone++;
      if (actual == required) begin
         checksPassed++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
      end
   endtask

   // Whole-state comparison reporting the first differing cell and the number of bad cells.
   task automatic checkOutputVec(input string name, input vec_t actual, input vec_t required);
      int diffCount;
      int firstDiff;
      diffCount = 0;
      firstDiff = -1;
      for (int n = 0; n < NUM_CELLS; n++) begin
         if (actual[n] !== required[n]) begin
            diffCount++;
            if (firstDiff < 0) firstDiff = n;
         end
      end
      checksDone++;
      if (diffCount == 0) begin
         checksPassed++;
      end else begin
         $display("[TB] FAIL %s: %0d cells differ, first at addr %0d got %b expected %b",
                  name, diffCount, firstDiff, actual[firstDiff], required[firstDiff]);
      end
   endtask

   // Reference forward revaluate step along every row.
   function automatic vec_t forwardRevaluate(input vec_t a);
      vec_t b;
      int   base;
      b = '0;
      for (int k = 0; k < NUM_PAGE; k++) begin
         for (int j = 0; j < NUM_COLUMN; j++) begin
            base = k * NUM_ROW * NUM_COLUMN + j * NUM_ROW;
            for (int i = 0; i < NUM_ROW; i++) begin
               b[base + i] = a[base + i] ^
                             (~a[base + (i + 1) % NUM_ROW] & a[base + (i + 2) % NUM_ROW]);
            end
         end
      end
      return b;
   endfunction

   function automatic vec_t randomVec();
      vec_t v;
      v = '0;
      for (int w = 0; w < NUM_CELLS / 32; w++) begin
         v[w * 32 +: 32] = $urandom;
      end
      return v;
   endfunction

   // Wait for idle, launch one job, record its expectation, then scramble data_in.
   task automatic applyStimulus(input string name, input vec_t b, input vec_t expected);
      exp_t entry;
      int   waited;
      waited = 0;
      @(negedge clock);
      while (busy && waited < 5000) begin
         @(negedge clock);
         waited++;
      end
      if (busy) checkOutput({name, "_idleTimeout"}, 1, 0);
      dataIn = b;
      start  = 1'b1;
      @(posedge clock);
      #1;
      entry.name        = name;
      entry.expected    = expected;
      entry.acceptCycle = cycleCount;
      expQ.push_back(entry);
      @(negedge clock);
      start  = 1'b0;
      dataIn = ~b;
   endtask

   // Block until the scoreboard has drained, with a bounded wait.
   task automatic waitDrain(input string name);
      int waited;
      waited = 0;
      while (expQ.size() != 0 && waited < NUM_CELLS + 400) begin
         @(negedge clock);
         waited++;
      end
      if (expQ.size() != 0) begin
         checkOutput({name, "_doneTimeout"}, 0, 1);
         expQ.delete();
      end
   endtask

   // Monitor: each done pulse is matched against the oldest outstanding job.
   always @(negedge clock) begin
      exp_t entry;
      if (done) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedDone", 1, 0);
         end else begin
            entry = expQ.pop_front();
            checkOutputVec({entry.name, "_data"}, dataOut, entry.expected);
            checkOutput({entry.name, "_latency"}, cycleCount - entry.acceptCycle, NUM_CELLS);
            @(negedge clock);
            checkOutput({entry.name, "_doneWidth"}, done, 0);
            checkOutput({entry.name, "_busyDrop"}, busy, 0);
         end
      end
   end

   // Global time limit so the run always ends.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence.
   initial begin
      vec_t b;
      vec_t a;
      vec_t e;
      checksDone   = 0;
      checksPassed = 0;
      reset  = 1'b1;
      start  = 1'b0;
      dataIn = '0;
      repeat (3) @(negedge clock);
      checkOutput("resetBusy", busy, 0);
      checkOutput("resetDone", done, 0);
      checkOutputVec("resetData", dataOut, '0);
      reset = 1'b0;

      // All zeros in, all zeros out.
      applyStimulus("allZero", '0, '0);
      waitDrain("allZero");

      // All ones is a fixed point; start pulses during RUN must be ignored.
      applyStimulus("allOnes", '1, '1);
      repeat (100) @(negedge clock);
      start = 1'b1;
      repeat (3) @(negedge clock);
      start = 1'b0;
      waitDrain("allOnes");

      // Single bit at cell 0 -> cells 0,1,3 of row 0.
      b = '0; b[0] = 1'b1;
      e = '0; e[0] = 1'b1; e[1] = 1'b1; e[3] = 1'b1;
      applyStimulus("bit0", b, e);
      waitDrain("bit0");

      // Cells 0 and 3 -> only cell 0.
      b = '0; b[0] = 1'b1; b[3] = 1'b1;
      e = '0; e[0] = 1'b1;
      applyStimulus("bits0and3", b, e);
      waitDrain("bits0and3");

      // Single bit at i=2 of the very last row (base 1595) -> cells 1597,1598,1595.
      b = '0; b[1597] = 1'b1;
      e = '0; e[1597] = 1'b1; e[1598] = 1'b1; e[1595] = 1'b1;
      applyStimulus("lastRow", b, e);
      waitDrain("lastRow");

      // Random states pushed through the forward step must come back unchanged.
      for (int s = 0; s < NUM_RANDOM; s++) begin
         a = randomVec();
         applyStimulus($sformatf("random%0d", s), forwardRevaluate(a), a);
         waitDrain($sformatf("random%0d", s));
      end

      // Reset in the middle of a job, with stray start pulses while busy.
      a = randomVec();
      applyStimulus("aborted", forwardRevaluate(a), a);
      repeat (698) @(negedge clock);
      start = 1'b1;
      repeat (2) @(negedge clock);
      start = 1'b0;
      checkOutput("midRunBusy", busy, 1);
      reset = 1'b1;
      expQ.delete();
      #1;
      checkOutput("abortBusy", busy, 0);
      checkOutput("abortDone", done, 0);
      checkOutputVec("abortData", dataOut, '0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (20) @(negedge clock);
      checkOutput("postAbortIdle", busy, 0);

      // A fresh job after the abort completes with the normal latency.
      b = '0; b[0] = 1'b1; b[3] = 1'b1;
      e = '0; e[0] = 1'b1;
      applyStimulus("afterReset", b, e);
      waitDrain("afterReset");

      repeat (5) @(negedge clock);
      $display("%0d/%0d checks passed", checksPassed, checksDone);
      $finish;
   end

endmodule
